valu_issue_ctrl: RTL and testbench
==================================

// Module: valu_issue_ctrl
// PURPOSE
//  Issue/sequencing controller for vector_alu. Accepts ops via valid/ready, blocks RAW/WAW hazards
//  with scalar+vector scoreboards, drives alu_op/alu_en. Tracks in-flight ops in a LATENCY-deep
//  valid/tag shift register (the ALU carries no valid bit). Presents results to writeback with
//  valid/ready, freezing the ALU pipe on backpressure. Sits between decode and vector_alu/regfiles.
// PARAMETERS
//  LATENCY  8   issue-to-result cycles of vector_alu (uniform for all ops), >=2
//  NREGS    32  registers per file (scalar and vector); REG_W = $clog2(NREGS)
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      asynchronous active-low reset
//  issue_valid    in   1      op presented
//  issue_ready    out  1      op accepted this cycle (fire = valid & ready)
//  issue_op       in   5      valu_op_e opcode
//  issue_dst      in   REG_W  destination register
//  issue_srca/b   in   REG_W  source registers a/b
//  issue_srca/b_vec in 1      source a/b in vector file (0 = scalar file)
//  issue_srca/b_use in 1      source a/b read by this op
//  flush          in   1      kill all in-flight ops
//  alu_en         out  1      vector_alu enable (pipe advance)
//  alu_op         out  5      vector_alu op (issue_op on fire, else Fadd bubble)
//  wb_valid       out  1      result at ALU output valid
//  wb_ready       in   1      writeback accepts
//  wb_dst         out  REG_W  result destination
//  wb_vec         out  1      1 = vector file (vout), 0 = scalar file (rout)
//  illegal_op     out  1      one-cycle pulse: opcode > Vmin accepted and dropped
// BEHAVIOUR
//  - Reset: all stage valids 0, scoreboards clear; alu_en=1, issue_ready=0 during reset,
//    wb_valid=0, wb_dst=0, wb_vec=0, illegal_op=0, alu_op=0.
//  - stall = valid[LATENCY] & ~wb_ready. alu_en = ~stall. On stall shift register holds.
//  - hazard = (srca_use & busy(srca,srca_vec)) | (srcb_use & busy(srcb,srcb_vec)) | busy(dst,dst_vec).
//  - issue_ready = ~flush & ~stall & ~hazard (combinational; illegal ops skip hazard check).
//  - Fire (legal op): stage1 <= {1,dst,is_vector_result(op)}; set scoreboard bit; alu_op=issue_op.
//    No fire or illegal op: stage1 valid <= 0 (bubble), alu_op=Fadd.
//  - Latency: fire at cycle t -> wb_valid at t+LATENCY with no stalls; +1 per stall cycle.
//  - wb_valid=valid[LATENCY]; wb_dst/wb_vec from same stage. Retire = wb_valid & wb_ready clears
//    scoreboard bit that cycle. Busy reg is not released same-cycle: issue to/from retiring reg
//    blocks one extra cycle (no bypass).
//  - Result class: scalar = Fadd,Fsub,Fmult,Vdot,Vdota,Vindx,Vreduce; all other legal ops vector.
//  - flush: next edge clears all stage valids and both scoreboards; issue_ready=0 that cycle;
//    a retire coincident with flush is still reported (wb_valid seen) but flush wins on state.
//  - Full pipe: no limit beyond hazards; one op/cycle sustained when independent and wb_ready=1.
//  - Reset mid-operation: in-flight ops discarded, no wb_valid after deassertion until new fire.
// CONFIGURATION
//  VALU_PERF_CNT_EN defined: adds outputs perf_issued[31:0] (legal fires), perf_stall[31:0]
//  (stall cycles), perf_hazard[31:0] (issue_valid & hazard cycles); wrap at 2^32, reset 0,
//  unaffected by flush. Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  valu_pkg: valu_op_e enum (Fadd=0 ... Vmin=18), VALU_OP_W=5, function is_vector_result(op),
//  function is_legal_op(op). Sub-module valu_scoreboard (two NREGS bit-vectors, set/clear ports,
//  two read-check ports plus dst check); pipe tag shift register stays in top.
// TESTING
//  1 Independent Vadd dst v1 at t=0, wb_ready=1 -> wb_valid=1,wb_dst=1,wb_vec=1 at t=8 only.
//  2 Fadd dst s3 then Fmult srca s3 -> second held issue_ready=0 until cycle after s3 retires.
//  3 8 back-to-back independent ops, wb_ready=0 at t=8 for 3 cycles -> alu_en=0 3 cycles,
//    8 results in order, none lost or duplicated.
//  4 Vdot dst s5 issued, flush at t=4 -> no wb_valid thereafter; Fadd dst s5 accepted t=5.
//  5 issue_op=25 -> issue_ready=1, illegal_op pulse, no wb_valid, scoreboard unchanged.
//  6 Reset asserted at t=3 with 3 ops in flight -> outputs at reset values, no wb_valid post-reset.

Source files
------------

// File: rtl/valu_pkg.sv
// rtl/valu_pkg.sv - vector_alu opcode enum, widths and opcode classification helpers
// Ports: none (package).
package valu_pkg;

  localparam int VALU_OP_W = 5;

  typedef enum logic [VALU_OP_W-1:0] {
    Fadd    = 5'd0,
    Fsub    = 5'd1,
    Fmult   = 5'd2,
    Vadd    = 5'd3,
    Vsub    = 5'd4,
    Vmult   = 5'd5,
    Vdot    = 5'd6,
    Vdota   = 5'd7,
    Vindx   = 5'd8,
    Vreduce = 5'd9,
    Vsplat  = 5'd10,
    Vscale  = 5'd11,
    Vand    = 5'd12,
    Vor     = 5'd13,
    Vxor    = 5'd14,
    Vshl    = 5'd15,
    Vshr    = 5'd16,
    Vmax    = 5'd17,
    Vmin    = 5'd18
  } valu_op_e;

  function automatic logic is_legal_op(input logic [VALU_OP_W-1:0] op);
    return (op <= Vmin);
  endfunction

  // Ops that collapse to a scalar land in the scalar file; everything else
  // legal writes the vector file.
  function automatic logic is_vector_result(input logic [VALU_OP_W-1:0] op);
    logic scalar;
    scalar = op inside {Fadd, Fsub, Fmult, Vdot, Vdota, Vindx, Vreduce};
    return is_legal_op(op) & ~scalar;
  endfunction

endpackage

// File: rtl/valu_issue_ctrl_if.sv
// rtl/valu_issue_ctrl_if.sv - issue, ALU-control and writeback signal bundle
// master: decode/writeback side (drives issue_*, flush, wb_ready).
// slave : valu_issue_ctrl (drives issue_ready, alu_en, alu_op, wb_*, illegal_op).
interface valu_issue_ctrl_if
  import valu_pkg::*;
#(
  parameter int REG_W = 5
) ();
  logic                 issue_valid;
  logic                 issue_ready;
  logic [VALU_OP_W-1:0] issue_op;
  logic [REG_W-1:0]     issue_dst;
  logic [REG_W-1:0]     issue_srca;
  logic [REG_W-1:0]     issue_srcb;
  logic                 issue_srca_vec;
  logic                 issue_srcb_vec;
  logic                 issue_srca_use;
  logic                 issue_srcb_use;
  logic                 flush;
  logic                 alu_en;
  logic [VALU_OP_W-1:0] alu_op;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [REG_W-1:0]     wb_dst;
  logic                 wb_vec;
  logic                 illegal_op;

  modport master (
    output issue_valid, issue_op, issue_dst, issue_srca, issue_srcb,
           issue_srca_vec, issue_srcb_vec, issue_srca_use, issue_srcb_use,
           flush, wb_ready,
    input  issue_ready, alu_en, alu_op, wb_valid, wb_dst, wb_vec, illegal_op
  );

  modport slave (
    input  issue_valid, issue_op, issue_dst, issue_srca, issue_srcb,
           issue_srca_vec, issue_srcb_vec, issue_srca_use, issue_srcb_use,
           flush, wb_ready,
    output issue_ready, alu_en, alu_op, wb_valid, wb_dst, wb_vec, illegal_op
  );
endinterface

// File: rtl/valu_scoreboard.sv
// rtl/valu_scoreboard.sv - scalar and vector register busy bit-vectors
// Ports: clk, rst_n; flush clears both files; set_* marks a destination busy,
//        clr_* releases a retiring destination; chk_a/chk_b/chk_d return busy
//        for a register in the file selected by its *_vec bit.
module valu_scoreboard #(
  parameter  int NREGS = 32,
  localparam int REG_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_reg,
  input  logic             set_vec,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_reg,
  input  logic             clr_vec,
  input  logic [REG_W-1:0] chk_a_reg,
  input  logic             chk_a_vec,
  output logic             chk_a_busy,
  input  logic [REG_W-1:0] chk_b_reg,
  input  logic             chk_b_vec,
  output logic             chk_b_busy,
  input  logic [REG_W-1:0] chk_d_reg,
  input  logic             chk_d_vec,
  output logic             chk_d_busy
);
  logic [NREGS-1:0] sbusy, vbusy, sbusy_nx, vbusy_nx;

  always_comb begin
    sbusy_nx = sbusy;
    vbusy_nx = vbusy;
    if (clr_en && !clr_vec) sbusy_nx[clr_reg] = 1'b0;
    if (clr_en &&  clr_vec) vbusy_nx[clr_reg] = 1'b0;
    if (set_en && !set_vec) sbusy_nx[set_reg] = 1'b1;
    if (set_en &&  set_vec) vbusy_nx[set_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbusy <= '0;
      vbusy <= '0;
    end else if (flush) begin
      sbusy <= '0;
      vbusy <= '0;
    end else begin
      sbusy <= sbusy_nx;
      vbusy <= vbusy_nx;
    end
  end

  // Reads see registered state only, so a register retiring this cycle still
  // reads busy: no same-cycle release.
  assign chk_a_busy = chk_a_vec ? vbusy[chk_a_reg] : sbusy[chk_a_reg];
  assign chk_b_busy = chk_b_vec ? vbusy[chk_b_reg] : sbusy[chk_b_reg];
  assign chk_d_busy = chk_d_vec ? vbusy[chk_d_reg] : sbusy[chk_d_reg];
endmodule

// File: rtl/valu_issue_ctrl.sv
// rtl/valu_issue_ctrl.sv - vector_alu issue/sequencing controller with hazard scoreboards
// Ports: clk, rst_n (async active-low); bus (valu_issue_ctrl_if.slave): issue
//        handshake and operands, flush, alu_en/alu_op, writeback handshake, illegal_op.
// Optional VALU_PERF_CNT_EN: perf_issued, perf_stall, perf_hazard 32-bit counters.
module valu_issue_ctrl
  import valu_pkg::*;
#(
  parameter  int LATENCY = 8,
  parameter  int NREGS   = 32,
  localparam int REG_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  valu_issue_ctrl_if.slave  bus
`ifdef VALU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_hazard
`endif
);
  // The ALU carries no valid bit; this shift register mirrors its pipe.
  logic [LATENCY:1] stg_valid;
  logic [LATENCY:1] stg_vec;
  logic [REG_W-1:0] stg_dst [1:LATENCY];

  logic legal, dst_vec, stall, hazard, fire, fire_legal, retire;
  logic a_busy, b_busy, d_busy;

  assign legal      = is_legal_op(bus.issue_op);
  assign dst_vec    = is_vector_result(bus.issue_op);
  assign stall      = stg_valid[LATENCY] & ~bus.wb_ready;
  assign retire     = stg_valid[LATENCY] & bus.wb_ready;
  assign hazard     = (bus.issue_srca_use & a_busy) | (bus.issue_srcb_use & b_busy) | d_busy;
  // Illegal ops are dropped, so they never wait on the scoreboard.
  assign bus.issue_ready = rst_n & ~bus.flush & ~stall & (~legal | ~hazard);
  assign fire       = bus.issue_valid & bus.issue_ready;
  assign fire_legal = fire & legal;

  assign bus.alu_en     = ~stall;
  assign bus.alu_op     = fire_legal ? bus.issue_op : Fadd;
  assign bus.illegal_op = fire & ~legal;
  assign bus.wb_valid   = stg_valid[LATENCY];
  assign bus.wb_dst     = stg_dst[LATENCY];
  assign bus.wb_vec     = stg_vec[LATENCY];

  valu_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (bus.flush),
    .set_en     (fire_legal),
    .set_reg    (bus.issue_dst),
    .set_vec    (dst_vec),
    .clr_en     (retire),
    .clr_reg    (stg_dst[LATENCY]),
    .clr_vec    (stg_vec[LATENCY]),
    .chk_a_reg  (bus.issue_srca),
    .chk_a_vec  (bus.issue_srca_vec),
    .chk_a_busy (a_busy),
    .chk_b_reg  (bus.issue_srcb),
    .chk_b_vec  (bus.issue_srcb_vec),
    .chk_b_busy (b_busy),
    .chk_d_reg  (bus.issue_dst),
    .chk_d_vec  (dst_vec),
    .chk_d_busy (d_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      stg_vec   <= '0;
      for (int i = 1; i <= LATENCY; i++) stg_dst[i] <= '0;
    end else if (bus.flush) begin
      stg_valid <= '0;
    end else if (!stall) begin
      stg_valid  <= {stg_valid[LATENCY-1:1], fire_legal};
      stg_vec    <= {stg_vec[LATENCY-1:1], fire_legal & dst_vec};
      stg_dst[1] <= fire_legal ? bus.issue_dst : '0;
      for (int i = 2; i <= LATENCY; i++) stg_dst[i] <= stg_dst[i-1];
    end
  end

`ifdef VALU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_hazard <= '0;
    end else begin
      perf_issued <= perf_issued + 32'(fire_legal);
      perf_stall  <= perf_stall + 32'(stall);
      perf_hazard <= perf_hazard + 32'(bus.issue_valid & hazard);
    end
  end
`endif
endmodule

// File: tb/tb_valu_issue_ctrl.sv
// tb/tb_valu_issue_ctrl.sv - directed self-checking bench for valu_issue_ctrl
module tb_valu_issue_ctrl;
  import valu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  valu_issue_ctrl_if #(.REG_W(5)) bus ();

`ifdef VALU_PERF_CNT_EN
  logic [31:0] perf_issued, perf_stall, perf_hazard;
`endif

  valu_issue_ctrl #(.LATENCY(8), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef VALU_PERF_CNT_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
    .perf_hazard (perf_hazard)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.issue_valid    = 1'b0;
    bus.issue_op       = '0;
    bus.issue_dst      = '0;
    bus.issue_srca     = '0;
    bus.issue_srcb     = '0;
    bus.issue_srca_vec = 1'b0;
    bus.issue_srcb_vec = 1'b0;
    bus.issue_srca_use = 1'b0;
    bus.issue_srcb_use = 1'b0;
    bus.flush          = 1'b0;
    bus.wb_ready       = 1'b1;
  endtask

  task automatic put(input logic [4:0] op, input logic [4:0] dst,
                     input logic [4:0] sa, input logic sa_vec, input logic sa_use);
    bus.issue_valid    = 1'b1;
    bus.issue_op       = op;
    bus.issue_dst      = dst;
    bus.issue_srca     = sa;
    bus.issue_srca_vec = sa_vec;
    bus.issue_srca_use = sa_use;
  endtask

  task automatic drain();
    tick();
    idle();
    repeat (12) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   bus.issue_ready, 0);
    check({tag, "_alu_en"},  bus.alu_en, 1);
    check({tag, "_wbv"},     bus.wb_valid, 0);
    check({tag, "_wbdst"},   bus.wb_dst, 0);
    check({tag, "_wbvec"},   bus.wb_vec, 0);
    check({tag, "_illegal"}, bus.illegal_op, 0);
    check({tag, "_aluop"},   bus.alu_op, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) tick();
    put(Vadd, 5'd1, 5'd0, 1'b0, 1'b0);
    settle();
    check_reset_outputs("rst");
    idle();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single independent Vadd v1, result exactly LATENCY cycles later
    put(Vadd, 5'd1, 5'd0, 1'b0, 1'b0);
    settle();
    check("t1_ready", bus.issue_ready, 1);
    check("t1_aluop", bus.alu_op, 3);
    for (int t = 1; t <= 11; t++) begin
      tick();
      idle();
      settle();
      check($sformatf("t1_wbv_%0d", t), bus.wb_valid, (t == 8));
      if (t == 8) begin
        check("t1_wbdst", bus.wb_dst, 1);
        check("t1_wbvec", bus.wb_vec, 1);
      end
      if (t == 1) check("t1_aluop_bubble", bus.alu_op, 0);
    end
    drain();

    // 2: RAW on s3 holds Fmult until the cycle after Fadd retires
    put(Fadd, 5'd3, 5'd0, 1'b0, 1'b0);
    settle();
    check("t2_ready0", bus.issue_ready, 1);
    for (int t = 1; t <= 9; t++) begin
      tick();
      put(Fmult, 5'd4, 5'd3, 1'b0, 1'b1);
      settle();
      check($sformatf("t2_ready_%0d", t), bus.issue_ready, (t == 9));
      if (t == 8) begin
        check("t2_wbv", bus.wb_valid, 1);
        check("t2_wbdst", bus.wb_dst, 3);
        check("t2_wbvec", bus.wb_vec, 0);
      end
    end
    drain();

    // 3: eight back-to-back ops, writeback stalled 3 cycles
    for (int t = 0; t <= 7; t++) begin
      if (t > 0) tick();
      put(Vadd, 5'(10 + t), 5'd0, 1'b0, 1'b0);
      settle();
      check($sformatf("t3_ready_%0d", t), bus.issue_ready, 1);
    end
    for (int t = 8; t <= 19; t++) begin
      tick();
      idle();
      if (t >= 8 && t <= 10) bus.wb_ready = 1'b0;
      if (t == 9) put(Vadd, 5'd30, 5'd0, 1'b0, 1'b0);
      settle();
      if (t == 9) check("t3_ready_stall", bus.issue_ready, 0);
      check($sformatf("t3_alu_en_%0d", t), bus.alu_en, !(t >= 8 && t <= 10));
      check($sformatf("t3_wbv_%0d", t), bus.wb_valid, (t <= 18));
      if (t <= 18) check($sformatf("t3_wbdst_%0d", t), bus.wb_dst, (t <= 10) ? 10 : t - 1);
    end
    drain();

    // 4: flush kills in-flight Vdot s5; s5 free again the next cycle
    put(Vdot, 5'd5, 5'd0, 1'b0, 1'b0);
    settle();
    check("t4_ready0", bus.issue_ready, 1);
    for (int t = 1; t <= 3; t++) begin
      tick();
      idle();
    end
    tick();
    idle();
    bus.flush = 1'b1;
    put(Fadd, 5'd5, 5'd0, 1'b0, 1'b0);
    settle();
    check("t4_ready_flush", bus.issue_ready, 0);
    tick();
    idle();
    put(Fadd, 5'd5, 5'd0, 1'b0, 1'b0);
    settle();
    check("t4_ready_after", bus.issue_ready, 1);
    for (int t = 6; t <= 13; t++) begin
      tick();
      idle();
      settle();
      check($sformatf("t4_wbv_%0d", t), bus.wb_valid, (t == 13));
      if (t == 13) begin
        check("t4_wbdst", bus.wb_dst, 5);
        check("t4_wbvec", bus.wb_vec, 0);
      end
    end
    drain();

    // 5: illegal opcode accepted despite hazard, dropped, scoreboard untouched
    put(Vadd, 5'd20, 5'd0, 1'b0, 1'b0);
    settle();
    check("t5_ready0", bus.issue_ready, 1);
    tick();
    put(5'd25, 5'd20, 5'd20, 1'b1, 1'b1);
    settle();
    check("t5_ready_ill", bus.issue_ready, 1);
    check("t5_illegal", bus.illegal_op, 1);
    check("t5_aluop", bus.alu_op, 0);
    tick();
    put(Vadd, 5'd21, 5'd20, 1'b1, 1'b1);
    settle();
    check("t5_illegal_off", bus.illegal_op, 0);
    check("t5_ready_raw", bus.issue_ready, 0);
    for (int t = 3; t <= 9; t++) begin
      tick();
      settle();
      check($sformatf("t5_wbv_%0d", t), bus.wb_valid, (t == 8));
      check($sformatf("t5_ready_%0d", t), bus.issue_ready, (t == 9));
      if (t == 8) check("t5_wbdst", bus.wb_dst, 20);
    end
    drain();

    // 6: reset with three ops in flight discards them
    for (int t = 0; t <= 2; t++) begin
      if (t > 0) tick();
      put(Vadd, 5'(1 + t), 5'd0, 1'b0, 1'b0);
      settle();
      check($sformatf("t6_ready_%0d", t), bus.issue_ready, 1);
    end
    tick();
    idle();
    rst_n = 1'b0;
    settle();
    check_reset_outputs("t6_rst");
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      settle();
      check($sformatf("t6_wbv_%0d", t), bus.wb_valid, 0);
    end
    put(Vadd, 5'd1, 5'd1, 1'b1, 1'b1);
    settle();
    check("t6_ready_clear", bus.issue_ready, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
